// File: rtl/mod_mul_if.sv
// rtl/mod_mul_if.sv - start/busy/done handshake and operand/result bus for mod_mul
interface mod_mul_if #(
  parameter int W = 256
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] C;
  logic         busy;
  logic         done;

  modport master (
    output start, A, B,
    input  C, busy, done
  );

  modport slave (
    input  start, A, B,
    output C, busy, done
  );
endinterface

// File: rtl/mod_mul.sv
// rtl/mod_mul.sv - bit-serial interleaved modular multiplier, C = A*B mod PRIME, one multiplier bit per clock
module mod_mul #(
  parameter int           W     = 256,
  parameter logic [W-1:0] PRIME = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF
) (
  input logic     clk,
  input logic     rst,
  mod_mul_if.slave bus
);
  localparam int CW = $clog2(W);

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;
  logic [W-1:0]  r;
  logic [CW-1:0] cnt;
  logic [W-1:0]  c_r;
  logic          busy_r;
  logic          done_r;

  logic [W:0]    dbl;
  logic          dbl_ge;
  logic [W-1:0]  t;
  logic [W-1:0]  addend;
  logic [W:0]    sum;
  logic          sum_ge;
  logic [W-1:0]  u;

  // Both reductions compare the full W+1-bit value against PRIME; the
  // difference is exact in W bits once the compare says it is non-negative.
  always_comb begin
    dbl    = {r, 1'b0};
    dbl_ge = (dbl >= {1'b0, PRIME});
    t      = dbl_ge ? W'(dbl - {1'b0, PRIME}) : dbl[W-1:0];
    addend = b_r[cnt] ? a_r : '0;
    sum    = {1'b0, t} + {1'b0, addend};
    sum_ge = (sum >= {1'b0, PRIME});
    u      = sum_ge ? W'(sum - {1'b0, PRIME}) : sum[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      r      <= '0;
      cnt    <= '0;
      c_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r    <= bus.A;
            b_r    <= bus.B;
            r      <= '0;
            cnt    <= CW'(W - 1);
            busy_r <= 1'b1;
            state  <= MUL;
          end
        end
        MUL: begin
          r <= u;
          if (cnt == '0) begin
            c_r    <= u;
            done_r <= 1'b1;
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.C    = c_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

  // The running remainder must stay fully reduced for in-contract operands.
  assert property (@(posedge clk) disable iff (rst) (state == MUL) |-> (r < PRIME));

endmodule

// File: tb/tb_mod_mul.sv
// tb/tb_mod_mul.sv - scoreboard bench for mod_mul against a wide-arithmetic reference
module tb_mod_mul;
  localparam int           W = 256;
  localparam logic [W-1:0] P = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
  localparam int           N_RANDOM = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mod_mul_if #(.W(W)) bus ();

  mod_mul #(.W(W), .PRIME(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] c;
    int           acc;
  } exp_t;

  exp_t sb[$];
  int   done_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   inv_viol = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    logic [2*W-1:0] m;
    prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    m    = prod % {{W{1'b0}}, P};
    return m[W-1:0];
  endfunction

  function automatic logic [W-1:0] rnd_fe();
    logic [W-1:0] x;
    for (int i = 0; i < W / 32; i++) x[i*32 +: 32] = $urandom;
    if (x >= P) x = x - P;
    return x;
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.busy && (dut.r >= P)) inv_viol++;
      if (bus.done) begin
        done_cyc.push_back(cyc);
        chk_int("done_single_cycle", int'(prev_done), 0);
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb.pop_front();
          check("result_C", bus.C, e.c);
          chk_int("latency", cyc - e.acc, W);
          chk_int("busy_falls_with_done", int'(bus.busy), 0);
        end
      end
      prev_done = bus.done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] e);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.busy && n < W + 10) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: got busy=1 expected busy=0 within %0d cycles", W + 10);
    end
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    sb.push_back('{c: e, acc: cyc + 1});
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = rnd_fe();
    bus.B     = rnd_fe();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((bus.busy || sb.size() != 0) && n < 2 * W + 10) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: got busy=%0d pending=%0d expected 0 and 0", bus.busy, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic [W-1:0] x;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           acc;
    int           n;

    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_int("reset_busy", int'(bus.busy), 0);
    chk_int("reset_done", int'(bus.done), 0);
    check("reset_C", bus.C, '0);
    rst = 1'b0;

    issue(256'd3, 256'd5, 256'd15);
    issue(P - 1, P - 1, 256'd1);
    issue(256'd2, (P >> 1) + 1, 256'd1);
    issue(256'd0, P - 1, 256'd0);
    issue(P - 1, 256'd0, 256'd0);
    x = rnd_fe();
    issue(256'd1, x, x);
    wait_idle();

    // Start held high across three operations, operands scrambled mid-MUL.
    done_cyc.delete();
    acc = 0;
    n   = 0;
    while (n < 4 * (W + 1)) begin
      @(negedge clk);
      n++;
      if (!bus.busy) begin
        if (acc < 3) begin
          a         = rnd_fe();
          b         = rnd_fe();
          bus.A     = a;
          bus.B     = b;
          bus.start = 1'b1;
          sb.push_back('{c: ref_mul(a, b), acc: cyc + 1});
          acc++;
        end else begin
          bus.start = 1'b0;
          break;
        end
      end else begin
        bus.A = rnd_fe();
        bus.B = rnd_fe();
      end
    end
    bus.start = 1'b0;
    wait_idle();
    chk_int("b2b_done_count", done_cyc.size(), 3);
    if (done_cyc.size() == 3) begin
      chk_int("b2b_spacing_1", done_cyc[1] - done_cyc[0], W + 1);
      chk_int("b2b_spacing_2", done_cyc[2] - done_cyc[1], W + 1);
    end

    // Reset during MUL discards the operation.
    issue(rnd_fe(), rnd_fe(), '0);
    repeat (99) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    chk_int("midrst_busy", int'(bus.busy), 0);
    chk_int("midrst_done", int'(bus.done), 0);
    check("midrst_C", bus.C, '0);
    issue(256'd7, 256'd9, 256'd63);
    wait_idle();

    for (int i = 0; i < N_RANDOM; i++) begin
      a = rnd_fe();
      b = rnd_fe();
      issue(a, b, ref_mul(a, b));
    end
    wait_idle();

    chk_int("r_below_prime", inv_viol, 0);
    chk_int("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
